// File: rtl/cla_nibble_seq.sv
// Sequential W-bit adder that reuses an external 4-bit CLA slice, one nibble per cycle, LSB first.
// Optional signed-overflow output res_ovf is built when CLA_NIBBLE_SEQ_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// RUN   | one nibble through the slice per cycle
// DONE  | result held; out_valid high until out_ready
module cla_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout
`ifdef CLA_NIBBLE_SEQ_OVF_EN
  ,
  output logic                   res_ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [CW+1:0] base;

  assign base = {cnt_q, 2'b00};

`ifdef CLA_NIBBLE_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign res_ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[base +: 4];
        add_b   = b_q[base +: 4];
        add_cin = (cnt_q == '0) ? cin_q : carry_q;
        sum_d[base +: 4] = add_sum;
        carry_d = add_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = add_cout;
          // the top nibble's MSB is add_sum[3] on this cycle
`ifdef CLA_NIBBLE_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq: behavioural 4-bit slice, vector table, hand sequences, random scoreboard run.
module tb_cla_nibble_seq;
  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_cin, add_cin, add_cout, out_valid, out_ready, res_cout;
  logic [15:0] op_a, op_b, res_sum;
  logic [3:0]  add_a, add_b, add_sum;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
  logic        res_ovf;
`endif

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  cla_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sum(res_sum), .res_cout(res_cout)
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] sum;
    logic        cout, ovf;
    logic [3:0]  cins;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  int         total = 0, bad = 0, cyc = 0, arm = 0, n_acc = 0, n_out = 0, n_drop = 0;
  logic [3:0] cin_bits;

  function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic cin);
    logic [16:0] t;
    exp_t e;
    t      = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.sum  = t[15:0];
    e.cout = t[16];
    e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // inputs are set at a falling edge; handshakes for the next rising edge are scored here
  task automatic tick();
    exp_t e;
    #1;
    if (rst) begin
      n_drop += sb.size();
      sb.delete();
      arm = 0;
    end else begin
      if (arm > 0) begin
        cin_bits[NIB-arm] = add_cin;
        arm--;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(op_a, op_b, op_cin));
        arm = NIB;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: out_valid with no pending pair, sum %0h", res_sum);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", res_sum, e.sum);
          chk("sb_cout", res_cout, e.cout);
`ifdef CLA_NIBBLE_SEQ_OVF_EN
          chk("sb_ovf", res_ovf, e.ovf);
`endif
          n_out++;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("wait_ready", in_ready, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] s, output logic c, output logic ov,
                       output logic [3:0] cins, output int lat);
    out_ready = 1'b1;
    wait_ready();
    op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom_range(0, 1));
    wait_valid(lat);
    s = res_sum; c = res_cout; cins = cin_bits;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    ov = res_ovf;
`else
    ov = 1'b0;
`endif
    tick();
  endtask

  initial begin
    logic [15:0] s;
    logic        c, ov;
    logic [3:0]  cins;
    int          lat, acc0, out0, guard;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'b1111};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'b0000};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 4'b0001};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cout", res_cout, 0);
    chk("rst_add_bus", {add_a, add_b, add_cin}, 0);
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    chk("rst_ovf", res_ovf, 0);
`endif

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, ov, cins, lat);
      chk("tbl_sum", s, vecs[i].sum);
      chk("tbl_cout", c, vecs[i].cout);
      chk("tbl_cins", cins, vecs[i].cins);
      chk("tbl_latency", lat, NIB);
`ifdef CLA_NIBBLE_SEQ_OVF_EN
      chk("tbl_ovf", ov, vecs[i].ovf);
`endif
    end

    // backpressure in DONE with a second pair already offered
    out_ready = 1'b0;
    wait_ready();
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; in_valid = 1'b1;
    tick();
    op_a = 16'h0F0F; op_b = 16'h0101; op_cin = 1'b1;
    wait_valid(lat);
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum", res_sum, 16'h3333);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_add_a", add_a, 0);
      tick();
    end
    chk("bp_no_accept", n_acc, acc0);
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    tick();
    chk("bp_second_accept", n_acc, acc0 + 1);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_second_sum", res_sum, 16'h1011);
    tick();

    // reset during the second RUN cycle
    wait_ready();
    op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_in_ready", in_ready, 1);
    chk("rr_sum", res_sum, 0);
    chk("rr_cout", res_cout, 0);
    out0 = n_out;
    for (int i = 0; i < 8; i++) begin
      chk("rr_no_valid", out_valid, 0);
      tick();
    end
    chk("rr_no_result", n_out, out0);
    do_op(16'h0001, 16'h0001, 1'b0, s, c, ov, cins, lat);
    chk("rr_after_sum", s, 16'h0002);
    chk("rr_after_cout", c, 0);

    // random traffic against the model
    out0 = n_out;
    guard = 0;
    while ((n_out - out0) < 3000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op_a      = 16'($urandom);
      op_b      = 16'($urandom);
      op_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rand_enough", (n_out - out0) >= 3000, 1);
    chk("rand_drained", sb.size(), 0);
    chk("one_result_per_accept", n_out + n_drop, n_acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
